// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: format codes and major-opcode constants shared by the immediate generator.
package imm_gen_pkg;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_C    = 3'd6
  } fmt_t;
  localparam logic [4:0] OPC_LOAD      = 5'd0;
  localparam logic [4:0] OPC_MISC_MEM  = 5'd3;
  localparam logic [4:0] OPC_OP_IMM    = 5'd4;
  localparam logic [4:0] OPC_AUIPC     = 5'd5;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'd6;
  localparam logic [4:0] OPC_STORE     = 5'd8;
  localparam logic [4:0] OPC_LUI       = 5'd13;
  localparam logic [4:0] OPC_BRANCH    = 5'd24;
  localparam logic [4:0] OPC_JALR      = 5'd25;
  localparam logic [4:0] OPC_JAL       = 5'd27;
  localparam logic [4:0] OPC_SYSTEM    = 5'd28;
endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: combinational instruction-to-{imm,fmt} decode; IMMGEN_RVC_EN adds compressed decode.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt
);
  logic [4:0] opc;
  logic [31:0] i32, i_imm, s_imm, b_imm, u_imm, j_imm;
  assign opc   = instr[6:2];
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMMGEN_RVC_EN
  // Keyed on {quadrant, funct3}; all results already sign- or zero-extended to 32 bits.
  function automatic logic [31:0] rvc_imm(input logic [15:0] c);
    case ({c[1:0], c[15:13]})
      5'b01_000, 5'b01_010: return 32'($signed({c[12], c[6:2]}));
      5'b01_011:            return 32'($signed({c[12], c[6:2], 12'b0}));
      5'b01_101:            return 32'($signed({c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0}));
      5'b01_110, 5'b01_111: return 32'($signed({c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0}));
      5'b00_010, 5'b00_110: return {25'b0, c[5], c[12:10], c[6], 2'b0};
      5'b10_010:            return {24'b0, c[3:2], c[12], c[6:4], 2'b0};
      5'b10_110:            return {24'b0, c[8:7], c[12:9], 2'b0};
      default:              return '0;
    endcase
  endfunction
`endif
  always_comb begin
    fmt = FMT_NONE;
    i32 = '0;
    if (instr[1:0] == 2'b11) begin
      case (opc)
        OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin fmt = FMT_I; i32 = i_imm; end
        OPC_OP_IMM_32: if (XLEN == 64) begin fmt = FMT_I; i32 = i_imm; end
        OPC_STORE:     begin fmt = FMT_S; i32 = s_imm; end
        OPC_BRANCH:    begin fmt = FMT_B; i32 = b_imm; end
        OPC_AUIPC, OPC_LUI: begin fmt = FMT_U; i32 = u_imm; end
        OPC_JAL:       begin fmt = FMT_J; i32 = j_imm; end
        default: ;
      endcase
    end
`ifdef IMMGEN_RVC_EN
    else begin
      fmt = FMT_C;
      i32 = rvc_imm(instr[15:0]);
    end
`endif
  end
  assign imm = XLEN'($signed(i32));
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with 2-entry skid buffer and flush.
// Optional compressed decode enabled by defining IMMGEN_RVC_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt
);
  logic [XLEN-1:0] dec_imm, main_imm, skid_imm;
  fmt_t dec_fmt, main_fmt, skid_fmt;
  logic [31:0] main_instr, skid_instr;
  logic main_v, skid_v, acc, adv;
  imm_decode_comb #(.XLEN(XLEN)) u_dec (.instr(in_instr), .imm(dec_imm), .fmt(dec_fmt));
  assign in_ready  = !skid_v;
  assign acc       = in_valid & in_ready;
  assign adv       = !main_v | out_ready;
  assign out_valid = main_v;
  assign out_instr = main_instr;
  assign out_imm   = main_imm;
  assign out_fmt   = main_fmt;
  // Skid only fills while main is stalled, so it never accepts while it is draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v     <= 1'b0;
      main_instr <= '0;
      main_imm   <= '0;
      main_fmt   <= FMT_NONE;
      skid_v     <= 1'b0;
      skid_instr <= '0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_NONE;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (adv) begin
      main_v <= skid_v | acc;
      skid_v <= 1'b0;
      if (skid_v) begin
        main_instr <= skid_instr;
        main_imm   <= skid_imm;
        main_fmt   <= skid_fmt;
      end else if (acc) begin
        main_instr <= in_instr;
        main_imm   <= dec_imm;
        main_fmt   <= dec_fmt;
      end
    end else if (acc) begin
      skid_v     <= 1'b1;
      skid_instr <= in_instr;
      skid_imm   <= dec_imm;
      skid_fmt   <= dec_fmt;
    end
  end
endmodule
